if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single outstanding request and delayed branch redirect
//
// Purpose: fetches one instruction word at a time from instruction memory
// and presents it to decode. Exactly one memory request is outstanding at any
// time. A taken branch consumed by decode is honoured after the delay-slot
// instruction (pc+4) has been fetched.
//
// Ports:
//   clk                      clock, all state updates on rising edge
//   rst                      asynchronous active-low reset
//   inst_req_o               fetch request to instruction memory
//   inst_addr_o              word-aligned fetch address (0 when not requesting)
//   inst_gnt_i               memory accepts the request this cycle
//   inst_rvalid_i            read data valid this cycle
//   inst_rdata_i             fetched instruction word
//   pc_o                     address of inst_o
//   inst_o                   instruction to decode, 0 (NOP) when not valid
//   inst_valid_o             inst_o/pc_o hold a live instruction
//   stall_i                  decode cannot consume this cycle
//   branch_flag_i            consumed instruction is a taken branch/jump
//   branch_target_address_i  redirect target for branch_flag_i

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_gnt_i,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] fetch_pc;
  logic        redirect_pending;
  logic [31:0] saved_target;

  logic        consume;
  logic        capture;
  logic [31:0] target_aligned;
  logic [31:0] seq_pc;

  // Decode takes the held instruction only when not stalled; data is only
  // accepted while waiting, so early/late rvalid is dropped by construction.
  assign consume        = (state == S_VALID) && !stall_i;
  assign capture        = (state == S_WAIT) && inst_rvalid_i;
  assign target_aligned = branch_target_address_i & 32'hFFFF_FFFC;
  assign seq_pc         = fetch_pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    inst_req_o  = 1'b0;
    inst_addr_o = 32'h0;
    case (state)
      S_IDLE: begin
        next_state = S_REQ;
      end
      S_REQ: begin
        inst_req_o  = 1'b1;
        inst_addr_o = fetch_pc;
        if (inst_gnt_i) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_rvalid_i) begin
          next_state = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall_i) begin
          next_state = S_REQ;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc         <= RESET_PC;
      redirect_pending <= 1'b0;
      saved_target     <= 32'h0;
      pc_o             <= 32'h0;
      inst_o           <= 32'h0;
      inst_valid_o     <= 1'b0;
    end else begin
      if (capture) begin
        inst_o       <= inst_rdata_i;
        pc_o         <= fetch_pc;
        inst_valid_o <= 1'b1;
      end
      if (consume) begin
        inst_o       <= 32'h0;
        inst_valid_o <= 1'b0;
        // A pending redirect means the instruction just consumed was the
        // delay slot, so the next fetch goes to the remembered target.
        if (redirect_pending) begin
          fetch_pc <= saved_target;
        end else begin
          fetch_pc <= seq_pc;
        end
        // A branch sitting in a delay slot replaces the target but keeps
        // pending set, so its own delay slot (the old target) runs first.
        if (branch_flag_i) begin
          redirect_pending <= 1'b1;
          saved_target     <= target_aligned;
        end else begin
          redirect_pending <= 1'b0;
        end
      end
    end
  end

endmodule
